// File: rtl/cap_sense_sweep_ctrl_if.sv
// Pad-array sweep bus: run control and raw pad inputs in, drive pin and
// published readings out. The sweep controller sits on the slave side.
interface cap_sense_sweep_ctrl_if #(
    parameter int NUM_CH = 9
);
    logic                   enable;
    logic [NUM_CH-1:0]      sense_in;
    logic                   sense_drive;
    logic [32*NUM_CH-1:0]   readings;
    logic [NUM_CH-1:0]      timeout_flags;
    logic                   sample_valid;
    logic                   busy;

    modport master (
        output enable, sense_in,
        input  sense_drive, readings, timeout_flags, sample_valid, busy
    );

    modport slave (
        input  enable, sense_in,
        output sense_drive, readings, timeout_flags, sample_valid, busy
    );
endinterface

// File: rtl/cap_sense_sweep_ctrl.sv
// Capacitive pad sweep sequencer: discharge, charge, time every pad's rise,
// and publish per-pad rise times averaged over 2^AVG_LOG2 sweeps.
//
// state     | meaning
// IDLE      | drive low, waiting for enable
// DISCHARGE | drive low for DISCHARGE_CYCLES clocks
// CHARGE    | drive high, latch each pad's rise index k
// PUBLISH   | accumulate; on last sweep of window update readings
module cap_sense_sweep_ctrl #(
    parameter int NUM_CH           = 9,
    parameter int DISCHARGE_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES   = 50000,
    parameter int AVG_LOG2         = 2
) (
    input logic                  clock,
    input logic                  reset,
    cap_sense_sweep_ctrl_if.slave bus
);
    localparam int AW = 32 + AVG_LOG2;
    localparam int SW = AVG_LOG2 + 1;
    localparam logic [SW-1:0] SWEEP_LAST = SW'((1 << AVG_LOG2) - 1);
    localparam logic [31:0]   DIS_LOAD   = 32'(DISCHARGE_CYCLES - 1);
    localparam logic [31:0]   K_LAST     = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   K_SAT      = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DISCHARGE, CHARGE, PUBLISH} state_t;

    state_t                 state;
    logic [31:0]            timer;
    logic [31:0]            kcnt;
    logic [SW-1:0]          sweep_cnt;
    logic [NUM_CH-1:0]      sync_a, sync_b;
    logic [NUM_CH-1:0]      latched, win_flags;
    logic [31:0]            count   [NUM_CH];
    logic [AW-1:0]          acc     [NUM_CH];
    logic [AW-1:0]          acc_sum [NUM_CH];
    logic                   drive, valid;
    logic [32*NUM_CH-1:0]   readings;
    logic [NUM_CH-1:0]      flags;
    logic                   all_done, last_k;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            acc_sum[i] = acc[i] + AW'(count[i]);
    end

    // A pad counts as done this cycle if already latched or its sync is high now
    assign all_done = &(latched | sync_b);
    assign last_k   = (kcnt == K_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            kcnt      <= '0;
            sweep_cnt <= '0;
            sync_a    <= '0;
            sync_b    <= '0;
            latched   <= '0;
            win_flags <= '0;
            drive     <= 1'b0;
            valid     <= 1'b0;
            readings  <= '0;
            flags     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                count[i] <= '0;
                acc[i]   <= '0;
            end
        end else begin
            sync_a <= bus.sense_in;
            sync_b <= sync_a;
            valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state <= DISCHARGE;
                        timer <= DIS_LOAD;
                    end
                end
                DISCHARGE: begin
                    if (timer == '0) begin
                        state   <= CHARGE;
                        drive   <= 1'b1;
                        kcnt    <= '0;
                        latched <= '0;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                CHARGE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (sync_b[i] && !latched[i]) begin
                            count[i]   <= kcnt;
                            latched[i] <= 1'b1;
                        end else if (last_k && !latched[i]) begin
                            count[i]     <= K_SAT;
                            win_flags[i] <= 1'b1;
                        end
                    end
                    kcnt <= kcnt + 32'd1;
                    if (all_done || last_k) begin
                        state <= PUBLISH;
                        drive <= 1'b0;
                    end
                end
                PUBLISH: begin
                    if (sweep_cnt == SWEEP_LAST) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            readings[32*i +: 32] <= 32'(acc_sum[i] >> AVG_LOG2);
                            acc[i]               <= '0;
                        end
                        flags     <= win_flags;
                        valid     <= 1'b1;
                        win_flags <= '0;
                        sweep_cnt <= '0;
                    end else begin
                        for (int i = 0; i < NUM_CH; i++)
                            acc[i] <= acc_sum[i];
                        sweep_cnt <= sweep_cnt + SW'(1);
                    end
                    if (bus.enable) begin
                        state <= DISCHARGE;
                        timer <= DIS_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sense_drive   = drive;
    assign bus.readings      = readings;
    assign bus.timeout_flags = flags;
    assign bus.sample_valid  = valid;
    assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_cap_sense_sweep_ctrl.sv
// Directed bench for the pad sweep sequencer: one unaveraged and one
// 4-sweep-averaging instance share clock, reset, enable and pad inputs.
module tb_cap_sense_sweep_ctrl;
    localparam int N = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [N-1:0] sense = '0;
    int           total = 0;
    int           bad   = 0;
    int           z, o, g, per;
    int           rt [4] = '{1, 2, 3, 5};

    always #5 clk = ~clk;

    cap_sense_sweep_ctrl_if #(.NUM_CH(N)) if0 ();
    cap_sense_sweep_ctrl_if #(.NUM_CH(N)) if1 ();

    assign if0.enable   = en;
    assign if0.sense_in = sense;
    assign if1.enable   = en;
    assign if1.sense_in = sense;

    cap_sense_sweep_ctrl #(.NUM_CH(N), .DISCHARGE_CYCLES(4), .TIMEOUT_CYCLES(100), .AVG_LOG2(0))
        dut0 (.clock(clk), .reset(rst), .bus(if0));
    cap_sense_sweep_ctrl #(.NUM_CH(N), .DISCHARGE_CYCLES(4), .TIMEOUT_CYCLES(100), .AVG_LOG2(2))
        dut1 (.clock(clk), .reset(rst), .bus(if1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [N-1:0] s);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sense = s;
        rst   = 1'b0;
        en    = 1'b1;
    endtask

    // Follows one sweep of dut0 at negedges; pad p rises raw at charge cycle rp,
    // the others at ra. Optionally drops enable or asserts reset at a charge cycle.
    task automatic sweep(input int p, input int rp, input int ra, input int drop_k,
                         input int rst_k, output int zc, output int oc, output int gc);
        int n;
        zc = 0; oc = 0; gc = 0;
        n = 0;
        while (!if0.busy && n < 20) begin @(negedge clk); n++; end
        if (!if0.busy) begin chk("busy_wait", 0, 1); return; end
        n = 0;
        while (if0.sense_drive == 1'b0 && n < 50) begin zc++; @(negedge clk); n++; end
        while (if0.sense_drive == 1'b1 && oc < 300) begin
            for (int i = 0; i < N; i++)
                sense[i] = (i == p) ? (oc >= rp) : (oc >= ra);
            if (oc == drop_k) en = 1'b0;
            if (oc == rst_k) begin rst = 1'b1; return; end
            oc++;
            @(negedge clk);
        end
        n = 0;
        while (!if0.sample_valid && n < 20) begin gc++; @(negedge clk); n++; end
        if (!if0.sample_valid) chk("valid_wait", 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_drive", if0.sense_drive, 0);
        chk("rst_read", if0.readings, 0);
        chk("rst_flags", if0.timeout_flags, 0);
        chk("rst_valid", if0.sample_valid, 0);
        chk("rst_busy", if0.busy, 0);
        chk("rst_read_avg", if1.readings[63:0], 0);

        // all pads time out
        start('0);
        sweep(3, 1000, 1000, -1, -1, z, o, g);
        chk("to_dis", z, 4);
        chk("to_chg", o, 100);
        chk("to_gap", g, 1);
        for (int i = 0; i < N; i++) chk("to_read", if0.readings[32*i +: 32], 100);
        chk("to_flags", if0.timeout_flags, 9'h1FF);
        @(negedge clk);
        chk("to_valid_pulse", if0.sample_valid, 0);

        // pad3 late, others at 5
        start('0);
        sweep(3, 10, 5, -1, -1, z, o, g);
        chk("rise_chg", o, 13);
        chk("rise_pad3", if0.readings[127:96], 12);
        chk("rise_pad0", if0.readings[31:0], 7);
        chk("rise_pad8", if0.readings[287:256], 7);
        chk("rise_flags", if0.timeout_flags, 0);

        // inputs tied high
        start('1);
        sweep(0, 0, 0, -1, -1, z, o, g);
        chk("hi_dis", z, 4);
        chk("hi_chg", o, 1);
        chk("hi_gap", g, 1);
        for (int i = 0; i < N; i++) chk("hi_read", if0.readings[32*i +: 32], 0);
        chk("hi_flags", if0.timeout_flags, 0);
        for (int r = 0; r < 2; r++) begin
            per = 0;
            do begin @(negedge clk); per++; end while (!if0.sample_valid && per < 50);
            chk("hi_period", per, 6);
        end

        // averaging window on dut1
        start('0);
        for (int s = 0; s < 4; s++) begin
            sweep(0, rt[s], 0, -1, -1, z, o, g);
            if (s == 0) chk("avg_raw_pad0", if0.readings[31:0], 3);
            chk("avg_valid", if1.sample_valid, (s == 3));
            chk("avg_pad0", if1.readings[31:0], (s == 3) ? 4 : 0);
            chk("avg_pad1", if1.readings[63:32], (s == 3) ? 2 : 0);
            sense = '0;
        end
        chk("avg_flags", if1.timeout_flags, 0);

        // enable drop mid-charge
        start('0);
        sweep(3, 1000, 1000, 50, -1, z, o, g);
        chk("drop_chg", o, 100);
        chk("drop_gap", g, 1);
        chk("drop_read", if0.readings[31:0], 100);
        chk("drop_busy", if0.busy, 0);
        chk("drop_drive", if0.sense_drive, 0);
        repeat (3) @(negedge clk);
        chk("drop_idle", if0.busy, 0);
        en = 1'b1;
        @(negedge clk);
        chk("reen_busy", if0.busy, 1);
        chk("reen_drive", if0.sense_drive, 0);

        // reset mid-charge with pad0 latched, readings still 100
        sweep(0, 0, 1000, -1, 20, z, o, g);
        @(negedge clk);
        chk("mrst_drive", if0.sense_drive, 0);
        chk("mrst_read", if0.readings, 0);
        chk("mrst_flags", if0.timeout_flags, 0);
        chk("mrst_valid", if0.sample_valid, 0);
        chk("mrst_busy", if0.busy, 0);
        sense = '0;
        rst   = 1'b0;
        sweep(0, 3, 3, -1, -1, z, o, g);
        chk("post_chg", o, 6);
        for (int i = 0; i < N; i++) chk("post_read", if0.readings[32*i +: 32], 5);
        chk("post_flags", if0.timeout_flags, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
